// File: rtl/dp_wakeup_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dp_wakeup_buffer
// Brief    : In-order dispatch FIFO between rename and the reservation
//            stations. Operands are filled at enqueue and keep snooping the
//            writeback buses until dispatch. Optional macro: DP_BYPASS_EN
//            (empty-buffer same-cycle pass-through).
// Revision : 1.0 - initial release
// ============================================================================

package dp_wakeup_pkg;
    localparam int PHYS_REG_BITS = 6;

    typedef logic [15:0] ctrl_word_t;

    typedef struct packed {
        logic                     valid;
        logic [31:0]              pc;
        logic [PHYS_REG_BITS-1:0] rd_paddr;
        logic                     rs1_rdy;
        logic [PHYS_REG_BITS-1:0] rs1_paddr;
        logic [31:0]              rs1_data;
        logic                     rs2_rdy;
        logic [PHYS_REG_BITS-1:0] rs2_paddr;
        logic [31:0]              rs2_data;
    } ooo_instr_t;
endpackage

module dp_wakeup_buffer
    import dp_wakeup_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int NUM_WB  = 2,
    parameter int PADDR_W = PHYS_REG_BITS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  ctrl_word_t                       in_ctrl,
    input  ooo_instr_t                       in_instr,
    input  logic                             prf_rs1_valid,
    input  logic                             prf_rs2_valid,
    input  logic [31:0]                      prf_rs1_v,
    input  logic [31:0]                      prf_rs2_v,
    input  logic [NUM_WB-1:0]                wb_valid,
    input  logic [NUM_WB-1:0][PADDR_W-1:0]   wb_paddr,
    input  logic [NUM_WB-1:0][31:0]          wb_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output ctrl_word_t                       out_ctrl,
    output ooo_instr_t                       out_instr,
    output logic [$clog2(DEPTH):0]           count
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Scanning from the top bus down lets the lowest-index match win.
    function automatic ooo_instr_t snoop(
        input ooo_instr_t                     e,
        input logic [NUM_WB-1:0]              v,
        input logic [NUM_WB-1:0][PADDR_W-1:0] pa,
        input logic [NUM_WB-1:0][31:0]        d
    );
        ooo_instr_t r;
        r = e;
        for (int k = NUM_WB - 1; k >= 0; k--) begin
            if (e.valid && !e.rs1_rdy && v[k] && (pa[k] == e.rs1_paddr)) begin
                r.rs1_rdy  = 1'b1;
                r.rs1_data = d[k];
            end
            if (e.valid && !e.rs2_rdy && v[k] && (pa[k] == e.rs2_paddr)) begin
                r.rs2_rdy  = 1'b1;
                r.rs2_data = d[k];
            end
        end
        return r;
    endfunction

    ctrl_word_t       ctrl_mem  [DEPTH];
    ooo_instr_t       instr_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;

    ooo_instr_t fill;
    ooo_instr_t head_fwd;
    logic       empty;
    logic       enq;
    logic       deq;
    logic       wr;
    logic       bypass;

    // PRF is applied first so a PRF-filled operand is ready before snooping.
    always_comb begin
        fill = in_instr;
        if (!in_instr.rs1_rdy && prf_rs1_valid) begin
            fill.rs1_rdy  = 1'b1;
            fill.rs1_data = prf_rs1_v;
        end
        if (!in_instr.rs2_rdy && prf_rs2_valid) begin
            fill.rs2_rdy  = 1'b1;
            fill.rs2_data = prf_rs2_v;
        end
        fill = snoop(fill, wb_valid, wb_paddr, wb_data);
    end

    assign head_fwd = snoop(instr_mem[head], wb_valid, wb_paddr, wb_data);
    assign empty    = (cnt == '0);
    assign in_ready = (cnt < DEPTH_C) & ~flush;
    assign enq      = in_valid & in_ready & in_instr.valid;

`ifdef DP_BYPASS_EN
    assign bypass = empty & enq;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = bypass | (~empty & ~flush);
    assign deq       = ~empty & ~flush & out_ready;
    assign wr        = enq & ~(bypass & out_ready);
    assign count     = cnt;

    always_comb begin
        out_ctrl  = '0;
        out_instr = '0;
        if (bypass) begin
            out_ctrl  = in_ctrl;
            out_instr = fill;
        end else if (!empty) begin
            out_ctrl  = ctrl_mem[head];
            out_instr = head_fwd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                ctrl_mem[i]  <= '0;
            end
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i].valid <= 1'b0;
            end
        end else begin
            // Tail and head coincide only when empty or full, never with both wr and deq.
            for (int i = 0; i < DEPTH; i++) begin
                if (wr && (PTR_W'(i) == tail)) begin
                    instr_mem[i] <= fill;
                    ctrl_mem[i]  <= in_ctrl;
                end else if (deq && (PTR_W'(i) == head)) begin
                    instr_mem[i].valid <= 1'b0;
                end else begin
                    instr_mem[i] <= snoop(instr_mem[i], wb_valid, wb_paddr, wb_data);
                end
            end
            if (wr) begin
                tail <= tail + PTR_W'(1);
            end
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            if (wr && !deq) begin
                cnt <= cnt + CNT_W'(1);
            end else if (!wr && deq) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dp_wakeup_buffer.sv
`default_nettype none
// Directed self-checking bench for dp_wakeup_buffer (DEPTH=4, NUM_WB=2);
// bypass-specific expectations follow DP_BYPASS_EN.
module tb_dp_wakeup_buffer;
    import dp_wakeup_pkg::*;

    localparam int DEPTH   = 4;
    localparam int NUM_WB  = 2;
    localparam int PADDR_W = PHYS_REG_BITS;
`ifdef DP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                           clk = 1'b0;
    logic                           rst_n = 1'b0;
    logic                           flush = 1'b0;
    logic                           in_valid = 1'b0;
    logic                           in_ready;
    ctrl_word_t                     in_ctrl = '0;
    ooo_instr_t                     in_instr = '0;
    logic                           prf_rs1_valid = 1'b0;
    logic                           prf_rs2_valid = 1'b0;
    logic [31:0]                    prf_rs1_v = '0;
    logic [31:0]                    prf_rs2_v = '0;
    logic [NUM_WB-1:0]              wb_valid = '0;
    logic [NUM_WB-1:0][PADDR_W-1:0] wb_paddr = '0;
    logic [NUM_WB-1:0][31:0]        wb_data = '0;
    logic                           out_valid;
    logic                           out_ready = 1'b0;
    ctrl_word_t                     out_ctrl;
    ooo_instr_t                     out_instr;
    logic [$clog2(DEPTH):0]         count;

    int checks = 0;
    int errors = 0;

    dp_wakeup_buffer #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .PADDR_W(PADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_instr(in_instr),
        .prf_rs1_valid(prf_rs1_valid), .prf_rs2_valid(prf_rs2_valid),
        .prf_rs1_v(prf_rs1_v), .prf_rs2_v(prf_rs2_v),
        .wb_valid(wb_valid), .wb_paddr(wb_paddr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_instr(out_instr), .count(count)
    );

    always #5 clk = ~clk;

    function automatic ooo_instr_t mk(input logic [31:0] pc,
                                      input logic [PHYS_REG_BITS-1:0] p1, input logic r1, input logic [31:0] d1,
                                      input logic [PHYS_REG_BITS-1:0] p2, input logic r2, input logic [31:0] d2);
        ooo_instr_t t;
        t = '0;
        t.valid = 1'b1; t.pc = pc; t.rd_paddr = PHYS_REG_BITS'(1);
        t.rs1_paddr = p1; t.rs1_rdy = r1; t.rs1_data = d1;
        t.rs2_paddr = p2; t.rs2_rdy = r2; t.rs2_data = d2;
        return t;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in_valid = 1'b0; flush = 1'b0; wb_valid = '0;
        prf_rs1_valid = 1'b0; prf_rs2_valid = 1'b0;
    endtask

    task automatic push(input ooo_instr_t ins);
        in_valid = 1'b1; in_instr = ins; in_ctrl = ins.pc[15:0];
        step;
        in_valid = 1'b0;
    endtask

    task automatic drain;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2 && count != 0; i++) step;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        checks++; if (out_instr !== '0) begin errors++; $display("FAIL rst_out_instr got %h want 0", out_instr); end
        checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL rst_out_ctrl got %h want 0", out_ctrl); end
        rst_n = 1'b1; step;
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) push(mk(32'(i), 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0));
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL pre_rst_count got %0d want 3", count); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        step; rst_n = 1'b1; step;
        for (int i = 0; i < 4; i++) push(mk(32'h10 + 32'(i), 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0));
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        in_valid = 1'b1; in_instr = mk(32'h14, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0);
        step; in_valid = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fifth_count got %0d want 4", count); end
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            checks++; if (out_valid !== 1'b1 || out_instr.pc !== 32'h10 + 32'(j) || out_ctrl !== 16'h10 + 16'(j)) begin
                errors++; $display("FAIL order_%0d got v=%b pc=%h ctrl=%h want v=1 pc=%h", j, out_valid, out_instr.pc, out_ctrl, 32'h10 + 32'(j));
            end
            step;
        end
        out_ready = 1'b0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL drained got count=%0d v=%b want 0 0", count, out_valid); end
    endtask

    task automatic test_fill_priority;
        idle; out_ready = 1'b0;
        prf_rs1_valid = 1'b1; prf_rs1_v = 32'hAAAA;
        wb_valid = 2'b01; wb_paddr[0] = 6'd5; wb_data[0] = 32'hBBBB;
        push(mk(32'h20, 6'd5, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0));
        idle;
        checks++; if (out_instr.rs1_rdy !== 1'b1 || out_instr.rs1_data !== 32'hAAAA) begin
            errors++; $display("FAIL prf_priority got rdy=%b data=%h want 1 0000aaaa", out_instr.rs1_rdy, out_instr.rs1_data);
        end
        wb_valid = 2'b11; wb_paddr[0] = 6'd5; wb_data[0] = 32'h11; wb_paddr[1] = 6'd5; wb_data[1] = 32'h22;
        push(mk(32'h21, 6'd5, 1'b0, 32'd0, 6'd5, 1'b1, 32'h77));
        idle;
        out_ready = 1'b1; step; out_ready = 1'b0;
        checks++; if (out_instr.pc !== 32'h21 || out_instr.rs1_rdy !== 1'b1 || out_instr.rs1_data !== 32'h11) begin
            errors++; $display("FAIL wb_lowest got pc=%h rdy=%b data=%h want 21 1 00000011", out_instr.pc, out_instr.rs1_rdy, out_instr.rs1_data);
        end
        checks++; if (out_instr.rs2_data !== 32'h77) begin errors++; $display("FAIL ready_kept got %h want 00000077", out_instr.rs2_data); end
        drain;
    endtask

    task automatic test_buffered_wakeup;
        idle; out_ready = 1'b0;
        push(mk(32'h30, 6'd0, 1'b1, 32'd0, 6'd9, 1'b0, 32'd0));
        checks++; if (out_instr.rs2_rdy !== 1'b0) begin errors++; $display("FAIL pre_wake_rdy got %b want 0", out_instr.rs2_rdy); end
        step;
        wb_valid = 2'b11; wb_paddr[0] = 6'd3; wb_data[0] = 32'h0BAD; wb_paddr[1] = 6'd9; wb_data[1] = 32'hDEAD;
        #1;
        checks++; if (out_instr.rs2_rdy !== 1'b1 || out_instr.rs2_data !== 32'hDEAD) begin
            errors++; $display("FAIL wake_fwd got rdy=%b data=%h want 1 0000dead", out_instr.rs2_rdy, out_instr.rs2_data);
        end
        step; idle;
        for (int i = 0; i < 2; i++) begin
            checks++; if (out_instr.rs2_rdy !== 1'b1 || out_instr.rs2_data !== 32'hDEAD) begin
                errors++; $display("FAIL wake_held_%0d got rdy=%b data=%h want 1 0000dead", i, out_instr.rs2_rdy, out_instr.rs2_data);
            end
            step;
        end
        drain;
    endtask

    task automatic test_deq_forward;
        idle; out_ready = 1'b0;
        push(mk(32'h40, 6'd7, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0));
        wb_valid = 2'b01; wb_paddr[0] = 6'd7; wb_data[0] = 32'h1234; out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b1 || out_instr.rs1_rdy !== 1'b1 || out_instr.rs1_data !== 32'h1234) begin
            errors++; $display("FAIL deq_fwd got v=%b rdy=%b data=%h want 1 1 00001234", out_valid, out_instr.rs1_rdy, out_instr.rs1_data);
        end
        step; idle; out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL deq_fwd_count got %0d want 0", count); end
    endtask

    task automatic test_bubble;
        idle; out_ready = 1'b0;
        in_valid = 1'b1; in_instr = mk(32'h45, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0); in_instr.valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bubble_comb got rdy=%b v=%b want 1 0", in_ready, out_valid); end
        step; in_valid = 1'b0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bubble_stored got count=%0d v=%b want 0 0", count, out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] q[$];
        logic [31:0] exp_pc;
        int          sent;
        bit          accept;
        bit          model_ov;
        idle; sent = 0;
        for (int cyc = 0; cyc < 60 && (sent < 10 || q.size() != 0); cyc++) begin
            out_ready = (cyc % 2 == 0);
            in_valid = (sent < 10);
            in_instr = mk(32'h100 + 32'(sent), 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0);
            in_ctrl = in_instr.pc[15:0];
            #1;
            accept = in_valid && (q.size() < DEPTH);
            model_ov = (q.size() != 0) || (BYP && accept);
            checks++; if (in_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL b2b_in_ready cyc%0d got %b want %b", cyc, in_ready, q.size() < DEPTH); end
            checks++; if (out_valid !== model_ov) begin errors++; $display("FAIL b2b_out_valid cyc%0d got %b want %b", cyc, out_valid, model_ov); end
            if (accept) q.push_back(in_instr.pc);
            if (model_ov && out_ready) begin
                exp_pc = q.pop_front();
                checks++; if (out_instr.pc !== exp_pc) begin errors++; $display("FAIL b2b_order cyc%0d got %h want %h", cyc, out_instr.pc, exp_pc); end
            end
            step;
            if (accept) sent++;
            checks++; if (count !== 3'(q.size()) || count > 3'd4) begin errors++; $display("FAIL b2b_count cyc%0d got %0d want %0d", cyc, count, q.size()); end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (sent != 10 || q.size() != 0) begin errors++; $display("FAIL b2b_timeout got sent=%0d left=%0d want 10 0", sent, q.size()); end
    endtask

    task automatic test_flush;
        idle; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(mk(32'h50 + 32'(i), 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0));
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL pre_flush_count got %0d want 3", count); end
        flush = 1'b1; in_valid = 1'b1; in_instr = mk(32'h53, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0);
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_comb got rdy=%b v=%b want 0 0", in_ready, out_valid); end
        step; idle;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear got count=%0d v=%b want 0 0", count, out_valid); end
        push(mk(32'h60, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0));
        checks++; if (count !== 3'd1 || out_valid !== 1'b1 || out_instr.pc !== 32'h60) begin
            errors++; $display("FAIL post_flush got count=%0d v=%b pc=%h want 1 1 60", count, out_valid, out_instr.pc);
        end
        drain;
    endtask

    task automatic test_latency;
        idle; out_ready = 1'b1;
        prf_rs1_valid = 1'b1; prf_rs1_v = 32'hCAFE;
        in_valid = 1'b1; in_instr = mk(32'h70, 6'd2, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0); in_ctrl = 16'h70;
        #1;
`ifdef DP_BYPASS_EN
        checks++; if (out_valid !== 1'b1 || out_instr.pc !== 32'h70 || out_instr.rs1_data !== 32'hCAFE) begin
            errors++; $display("FAIL bypass_same got v=%b pc=%h d=%h want 1 70 0000cafe", out_valid, out_instr.pc, out_instr.rs1_data);
        end
        step; idle;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bypass_count got count=%0d v=%b want 0 0", count, out_valid); end
`else
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_bypass got v=%b want 0", out_valid); end
        step; idle;
        checks++; if (out_valid !== 1'b1 || out_instr.pc !== 32'h70 || out_instr.rs1_data !== 32'hCAFE || count !== 3'd1) begin
            errors++; $display("FAIL latency1 got v=%b pc=%h d=%h count=%0d want 1 70 0000cafe 1", out_valid, out_instr.pc, out_instr.rs1_data, count);
        end
        step;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL latency_deq got %0d want 0", count); end
`endif
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_fill_priority;
        test_buffered_wakeup;
        test_deq_forward;
        test_bubble;
        test_back_to_back;
        test_flush;
        test_latency;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dp_wakeup_buffer.md
# dp_wakeup_buffer

Parametrised dispatch buffer between rename (RD) and the reservation stations. It accepts renamed instructions over a valid/ready handshake and fills unready source operands from the PRF read or any of NUM_WB writeback buses at enqueue. Instructions are held in a DEPTH-entry in-order FIFO, where every buffered operand keeps snooping all writeback buses until dispatch. It generalises the single-cycle dispatch stage with stall buffering, multi-bus wakeup and flush.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- NUM_WB, 2: writeback buses snooped.
- PADDR_W, PHYS_REG_BITS: physical register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush (mispredict).
- in_valid  in  1  RD offers an instruction.
- in_ready  out  1  buffer accepts the instruction this cycle.
- in_ctrl  in  ctrl_word_t  control word from RD.
- in_instr  in  ooo_instr_t  instruction struct from RD; uses rs1/rs2_rdy, rs1/rs2_data, rs1/rs2_paddr, valid.
- prf_rs1_valid, prf_rs2_valid  in  1  PRF read result valid for the operand.
- prf_rs1_v, prf_rs2_v  in  32  PRF read data.
- wb_valid  in  NUM_WB  per-bus writeback valid.
- wb_paddr  in  NUM_WB×PADDR_W  per-bus destination physical register.
- wb_data  in  NUM_WB×32  per-bus result.
- out_valid  out  1  head instruction presented to the RS.
- out_ready  in  1  RS has a free slot for the head instruction.
- out_ctrl  out  ctrl_word_t  head control word.
- out_instr  out  ooo_instr_t  head instruction struct, with operands including same-cycle wakeup.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Enqueue when in_valid & in_ready & in_instr.valid. If in_valid=1 and in_instr.valid=0, the beat is consumed as a bubble and nothing is stored.
- in_ready = (count < DEPTH) & ~flush.
- Enqueue operand fill applies per operand, and only when the incoming rdy=0:
  - First priority: a PRF valid operand takes the PRF data.
  - Otherwise: the lowest-index bus k with wb_valid[k] & wb_paddr[k]==paddr supplies the data.
  - The operand's rdy is set whenever either source supplies data.
- Buffered wakeup: every cycle, each valid entry whose operand is unready compares its paddr against all buses. On a match it sets rdy and latches data, lowest index winning. An operand that is already ready never changes.
- Head forwarding: out_instr is the head entry with the same-cycle buffered wakeup applied combinationally. A dequeue on a wakeup cycle therefore carries the woken value.
- Dequeue when out_valid & out_ready. out_valid = (count != 0) & ~flush.
- Simultaneous enqueue and dequeue while full is not allowed, because in_ready=0 when count==DEPTH. Simultaneous enqueue and dequeue at any other count leaves count unchanged.
- Head and tail pointers are $clog2(DEPTH) bits and wrap naturally. count is updated as +1 on enqueue only, −1 on dequeue only, and unchanged otherwise.
- flush clears all entry valids, both pointers and count on the next edge. flush takes priority over enqueue and dequeue in the same cycle.
- Storage holds no rename state; flush does not need to restore anything.

## Timing
- Reset (async, rst_n=0) sets count=0, pointers=0 and all entries invalid and zeroed. As a result out_valid=0, out_ctrl=0, out_instr=0 and in_ready=1.
- Deassertion of rst_n is synchronised externally; the block takes no action on it.
- Latency without bypass: an instruction enqueued at edge N is presented with out_valid=1 in cycle N+1 (visible after edge N).
- A wakeup on a bus in cycle C is visible in out_instr in cycle C (head forward) and registered at edge C+1.
- Throughput: 1 instruction per cycle sustained when out_ready stays 1.

## Configuration
- DP_BYPASS_EN defined: when count==0 and the enqueue condition holds, out_valid=1 in the same cycle, and out_ctrl/out_instr are driven from the filled input.
  - If out_ready=1, the instruction is consumed without being written and count stays 0.
  - If out_ready=0, the instruction is written normally.
- DP_BYPASS_EN undefined: no combinational in→out path; minimum latency is 1 cycle.

## Test plan
- Reset/fill: rst_n=0 mid-stream with count=3 → out_valid=0, count=0, in_ready=1 immediately. Then enqueue 4 instrs with out_ready=0 → count=4, in_ready=0; a 5th in_valid is not accepted.
- Enqueue fill priority: rs1_rdy=0, prf_rs1_valid=1 (0xAAAA), wb0 matching paddr 5 with 0xBBBB → stored rs1_data=0xAAAA. With prf invalid and both buses matching (wb0=0x11, wb1=0x22) → 0x11.
- Buffered wakeup: enqueue rs2 paddr 9 unready, hold out_ready=0 for 3 cycles; wb1 fires paddr 9 with 0xDEAD in cycle 2 → out_instr.rs2_rdy=1, rs2_data=0xDEAD in cycle 2 and thereafter.
- Dequeue-cycle forward: head rs1 unready paddr 7, wb0 fires paddr 7 with 0x1234 in the cycle out_ready=1 → dequeued out_instr.rs1_data=0x1234, rdy=1.
- Wrap and simultaneous: with DEPTH=4, stream 10 instrs with out_ready toggling 1,0,1… → in-order output, pointers wrap, count never exceeds 4, and simultaneous enqueue/dequeue keeps count unchanged.
- Flush: count=3, flush=1 with in_valid=1 → next cycle count=0, out_valid=0, and the flush-cycle input was not enqueued. With DP_BYPASS_EN and empty buffer, in_valid & out_ready → out_valid the same cycle, count stays 0.
